// File: rtl/bp_be_dcache_trace_pkg.sv
// Shared types for the dcache trace replay harness: trace entry / dcache pkt layouts and the
// replay state enum. Both layouts are parameterised, so they are declared through macros.
`ifndef BP_BE_DCACHE_TRACE_PKG_SV
`define BP_BE_DCACHE_TRACE_PKG_SV

`define BP_BE_DCACHE_TRACE_ENTRY_WIDTH(opcode_w, poff_w, ptag_w, dword_w) \
   (2 + (opcode_w) + (poff_w) + (ptag_w) + 2 * (dword_w))

`define DECLARE_BP_BE_DCACHE_TRACE_ENTRY_S(opcode_w, poff_w, ptag_w, dword_w) \
   typedef struct packed {                  \
      logic                  end_trace;     \
      logic                  check;         \
      logic [(opcode_w)-1:0] opcode;        \
      logic [(poff_w)-1:0]   page_offset;   \
      logic [(ptag_w)-1:0]   ptag;          \
      logic [(dword_w)-1:0]  wdata;         \
      logic [(dword_w)-1:0]  expected;      \
   } bp_be_dcache_trace_entry_s

`ifndef DECLARE_BP_BE_DCACHE_PKT_S
`define DECLARE_BP_BE_DCACHE_PKT_S(opcode_w, poff_w, dword_w) \
   typedef struct packed {                  \
      logic [(opcode_w)-1:0] opcode;        \
      logic [(poff_w)-1:0]   page_offset;   \
      logic [(dword_w)-1:0]  data;          \
   } bp_be_dcache_pkt_s
`endif

package bp_be_dcache_trace_pkg;

   typedef enum logic [1:0] {
      e_idle,
      e_run,
      e_drain,
      e_done
   } bp_be_dcache_trace_state_e;

endpackage

`endif

// File: rtl/bp_be_dcache_trace_expect_fifo.sv
// In-order FIFO of {check, expected} for ops accepted but not yet answered by the dcache.
// depth_p must be a power of 2 so the pointers wrap naturally.
module bp_be_dcache_trace_expect_fifo
   #(parameter int unsigned depth_p = 8
   , parameter int unsigned width_p = 65
   , localparam int unsigned ptr_width_lp = $clog2(depth_p)
   , localparam int unsigned count_width_lp = $clog2(depth_p + 1)
   )
   (input  logic                      clk_i
   , input  logic                      reset_n_i
   , input  logic                      clear_i
   , input  logic                      push_i
   , input  logic [width_p-1:0]        data_i
   , input  logic                      pop_i
   , output logic [width_p-1:0]        data_o
   , output logic [count_width_lp-1:0] count_o
   , output logic                      empty_o
   );

   logic [width_p-1:0]        mem_q [depth_p];
   logic [ptr_width_lp-1:0]   wptr_q, rptr_q;
   logic [count_width_lp-1:0] count_q;
   logic                      full;
   logic                      push_en, pop_en;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == count_width_lp'(depth_p));
   // A pop frees the slot the push writes, so push+pop is legal even when full.
   assign pop_en  = pop_i & !empty_o;
   assign push_en = push_i & (!full | pop_en);
   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) wptr_q <= wptr_q + 1'b1;
         if (pop_en)  rptr_q <= rptr_q + 1'b1;
         if (push_en && !pop_en) begin
            count_q <= count_q + 1'b1;
         end else if (pop_en && !push_en) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/bp_be_dcache_trace_replay.sv
// Trace ROM replay and load checker for the dcache harness. Define
// BP_BE_DCACHE_TRACE_REPLAY_TIMEOUT_EN to add a response watchdog (timeout_cycles_p).
module bp_be_dcache_trace_replay
   import bp_be_dcache_trace_pkg::*;
   #(parameter int unsigned opcode_width_p      = 5
   , parameter int unsigned page_offset_width_p = 12
   , parameter int unsigned ptag_width_p        = 28
   , parameter int unsigned dword_width_p       = 64
   , parameter int unsigned rom_addr_width_p    = 10
   , parameter int unsigned max_outstanding_p   = 8
`ifdef BP_BE_DCACHE_TRACE_REPLAY_TIMEOUT_EN
   , parameter int unsigned timeout_cycles_p    = 4096
`endif
   , localparam int unsigned entry_width_lp = `BP_BE_DCACHE_TRACE_ENTRY_WIDTH(
        opcode_width_p, page_offset_width_p, ptag_width_p, dword_width_p)
   , localparam int unsigned pkt_width_lp = opcode_width_p + page_offset_width_p + dword_width_p
   )
   (input  logic                        clk_i
   , input  logic                        reset_n_i
   , input  logic                        start_i
   , output logic [rom_addr_width_p-1:0] rom_addr_o
   , input  logic [entry_width_lp-1:0]   rom_data_i
   , output logic [pkt_width_lp-1:0]     pkt_o
   , output logic [ptag_width_p-1:0]     ptag_o
   , output logic                        pkt_v_o
   , input  logic                        pkt_ready_i
   , input  logic                        v_i
   , input  logic [dword_width_p-1:0]    data_i
   , output logic                        done_o
   , output logic                        error_o
   , output logic [15:0]                 err_count_o
   , output logic [31:0]                 resp_count_o
   );

   `DECLARE_BP_BE_DCACHE_TRACE_ENTRY_S(opcode_width_p, page_offset_width_p, ptag_width_p,
                                       dword_width_p);
   `DECLARE_BP_BE_DCACHE_PKT_S(opcode_width_p, page_offset_width_p, dword_width_p);

   localparam int unsigned expect_width_lp = 1 + dword_width_p;
   localparam int unsigned count_width_lp  = $clog2(max_outstanding_p + 1);

   bp_be_dcache_trace_entry_s entry;
   bp_be_dcache_pkt_s         pkt;

   bp_be_dcache_trace_state_e   state_q, state_d;
   logic [rom_addr_width_p-1:0] ptr_q, ptr_d;
   logic [31:0]                 resp_count_q, resp_count_d;
   logic [15:0]                 err_count_q, err_count_d;
   logic                        error_q, error_d;

   logic [expect_width_lp-1:0]  expect_head;
   logic [count_width_lp-1:0]   count;
   logic                        fifo_empty;
   logic                        accept;
   logic                        mismatch;
   logic                        timeout_hit;

   assign entry = rom_data_i;

   assign pkt.opcode      = entry.opcode;
   assign pkt.page_offset = entry.page_offset;
   assign pkt.data        = entry.wdata;

   // Full check uses the registered count: a same-cycle response does not open a slot.
   assign pkt_v_o = (state_q == e_run) & !entry.end_trace
                    & (count < count_width_lp'(max_outstanding_p));
   assign accept  = pkt_v_o & pkt_ready_i;

   // Payload is driven only while valid so the interface reads all-zero when idle or in reset.
   assign pkt_o      = pkt_v_o ? pkt : '0;
   assign ptag_o     = pkt_v_o ? entry.ptag : '0;
   assign rom_addr_o = ptr_q;

   assign mismatch = expect_head[dword_width_p] & (data_i != expect_head[dword_width_p-1:0]);

   bp_be_dcache_trace_expect_fifo
      #(.depth_p (max_outstanding_p)
      , .width_p (expect_width_lp)
      )
      expect_fifo
      (.clk_i     (clk_i)
      , .reset_n_i (reset_n_i)
      , .clear_i   (timeout_hit)
      , .push_i    (accept)
      , .data_i    ({entry.check, entry.expected})
      , .pop_i     (v_i)
      , .data_o    (expect_head)
      , .count_o   (count)
      , .empty_o   (fifo_empty)
      );

`ifdef BP_BE_DCACHE_TRACE_REPLAY_TIMEOUT_EN
   localparam int unsigned timer_width_lp = $clog2(timeout_cycles_p + 1);

   logic [timer_width_lp-1:0] timer_q, timer_d;

   // Fires on the cycle the timer would reach timeout_cycles_p with nothing answered.
   always_comb begin
      timer_d     = timer_q + 1'b1;
      timeout_hit = 1'b0;
      if (v_i || fifo_empty) begin
         timer_d = '0;
      end else if (timer_q == timer_width_lp'(timeout_cycles_p - 1)) begin
         timer_d     = '0;
         timeout_hit = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) timer_q <= '0;
      else            timer_q <= timer_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      resp_count_d = resp_count_q;
      err_count_d  = err_count_q;
      error_d      = error_q;

      unique case (state_q)
         e_idle: begin
            if (start_i) state_d = e_run;
         end
         e_run: begin
            if (entry.end_trace) begin
               state_d = e_drain;
            end else if (accept) begin
               // The last ROM address ends the trace instead of wrapping the pointer.
               if (ptr_q == '1) state_d = e_drain;
               else             ptr_d   = ptr_q + 1'b1;
            end
         end
         e_drain: begin
            if (fifo_empty) state_d = e_done;
         end
         e_done: begin
            state_d = e_done;
         end
         default: state_d = e_idle;
      endcase

      if (v_i) begin
         resp_count_d = resp_count_q + 32'd1;
         if (fifo_empty) begin
            error_d = 1'b1;
         end else if (mismatch) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
         end
      end

      if (timeout_hit) begin
         state_d = e_done;
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= e_idle;
         ptr_q        <= '0;
         resp_count_q <= '0;
         err_count_q  <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         resp_count_q <= resp_count_d;
         err_count_q  <= err_count_d;
         error_q      <= error_d;
      end
   end

   assign done_o       = (state_q == e_done);
   assign error_o      = error_q;
   assign err_count_o  = err_count_q;
   assign resp_count_o = resp_count_q;

endmodule

// File: tb/tb_bp_be_dcache_trace_replay.sv
// Directed bench for bp_be_dcache_trace_replay: trace ROM and an in-order dcache responder model.
module tb_bp_be_dcache_trace_replay;

   localparam int unsigned ent_w  = 2 + 5 + 12 + 28 + 128;
   localparam int unsigned pkt_w  = 5 + 12 + 64;
   localparam logic [4:0]  op_ld  = 5'd0;
   localparam logic [4:0]  op_sd  = 5'd1;

   logic              clk_i = 1'b0;
   logic              reset_n_i = 1'b0;
   logic              start_i = 1'b0;
   logic [9:0]        rom_addr_o;
   logic [ent_w-1:0]  rom_data_i;
   logic [pkt_w-1:0]  pkt_o;
   logic [27:0]       ptag_o;
   logic              pkt_v_o;
   logic              pkt_ready_i = 1'b0;
   logic              v_i = 1'b0;
   logic [63:0]       data_i = '0;
   logic              done_o;
   logic              error_o;
   logic [15:0]       err_count_o;
   logic [31:0]       resp_count_o;

   logic [ent_w-1:0]  rom [1024];
   logic [63:0]       dmem [4096];

   int                n_checks = 0;
   int                n_fail = 0;
   int                cyc = 0;
   int                acc_cnt = 0;
   logic              start_req = 1'b0;
   logic              rand_ready = 1'b0;
   logic              ready_fix = 1'b1;
   logic              auto_resp = 1'b1;
   logic              force_v = 1'b0;
   int                rel_cnt = 0;
   int                resp_delay = 2;
   logic [63:0]       xor_mask = '0;
   logic              hold = 1'b0;
   logic [pkt_w-1:0]  hold_pkt;
   logic [27:0]       hold_ptag;
   logic [63:0]       pend_data [$];
   int                pend_due [$];
   logic [pkt_w-1:0]  acc_pkt [$];
   logic [27:0]       acc_ptag [$];

   always #5 clk_i = ~clk_i;
   assign rom_data_i = rom[rom_addr_o];

   bp_be_dcache_trace_replay
      #(.max_outstanding_p (8)
`ifdef BP_BE_DCACHE_TRACE_REPLAY_TIMEOUT_EN
      , .timeout_cycles_p  (16)
`endif
      )
      dut
      (.clk_i        (clk_i)
      , .reset_n_i    (reset_n_i)
      , .start_i      (start_i)
      , .rom_addr_o   (rom_addr_o)
      , .rom_data_i   (rom_data_i)
      , .pkt_o        (pkt_o)
      , .ptag_o       (ptag_o)
      , .pkt_v_o      (pkt_v_o)
      , .pkt_ready_i  (pkt_ready_i)
      , .v_i          (v_i)
      , .data_i       (data_i)
      , .done_o       (done_o)
      , .error_o      (error_o)
      , .err_count_o  (err_count_o)
      , .resp_count_o (resp_count_o)
      );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int idx, input logic e, input logic c, input logic [4:0] op,
                      input logic [11:0] off, input logic [27:0] ptag, input logic [63:0] wd,
                      input logic [63:0] ex);
      rom[idx] = {e, c, op, off, ptag, wd, ex};
   endtask

   task automatic clear_bench();
      pend_data.delete();
      pend_due.delete();
      acc_pkt.delete();
      acc_ptag.delete();
      acc_cnt = 0;
      hold = 1'b0;
      rel_cnt = 0;
      force_v = 1'b0;
      start_req = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = '0;
      for (int i = 0; i < 4096; i++) dmem[i] = '0;
   endtask

   // One clock: drive inputs on the falling edge, model accepts, return 1 time unit after rise.
   task automatic step();
      logic [11:0] off;
      @(negedge clk_i);
      start_i = start_req;
      start_req = 1'b0;
      if (hold) begin
         check_eq("hold_v", pkt_v_o, 1);
         check_eq("hold_pkt", pkt_o, hold_pkt);
         check_eq("hold_ptag", ptag_o, hold_ptag);
      end
      pkt_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
      v_i = 1'b0;
      data_i = '0;
      if (force_v) begin
         v_i = 1'b1;
         force_v = 1'b0;
      end else if (pend_data.size() > 0 && (auto_resp ? (pend_due[0] <= cyc) : (rel_cnt > 0))) begin
         v_i = 1'b1;
         data_i = pend_data.pop_front();
         void'(pend_due.pop_front());
         if (!auto_resp) rel_cnt--;
      end
      if (pkt_v_o && pkt_ready_i) begin
         acc_cnt++;
         acc_pkt.push_back(pkt_o);
         acc_ptag.push_back(ptag_o);
         off = pkt_o[75:64];
         if (pkt_o[80:76] == op_sd) begin
            dmem[off] = pkt_o[63:0];
            pend_data.push_back(64'd0);
         end else begin
            pend_data.push_back(dmem[off] ^ xor_mask);
         end
         pend_due.push_back(cyc + resp_delay);
      end
      hold = pkt_v_o && !pkt_ready_i;
      hold_pkt = pkt_o;
      hold_ptag = ptag_o;
      @(posedge clk_i);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      start_i = 1'b0;
      v_i = 1'b0;
      pkt_ready_i = 1'b0;
      clear_bench();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_to_done(input string tag, input int budget);
      for (int i = 0; i < budget && !done_o; i++) step();
      check_eq(tag, done_o, 1);
   endtask

   task automatic load_store_trace();
      clear_rom();
      put(0, 1'b0, 1'b0, op_sd, 12'h010, 28'h0000_ABC, 64'hDEAD_BEEF, 64'd0);
      put(1, 1'b0, 1'b1, op_ld, 12'h010, 28'h0000_ABC, 64'd0, 64'hDEAD_BEEF);
      put(2, 1'b1, 1'b0, op_ld, 12'h000, 28'd0, 64'd0, 64'd0);
   endtask

   task automatic twenty_trace();
      clear_rom();
      for (int i = 0; i < 20; i++) begin
         dmem[i * 8] = 64'hA5A5_0000_0000_0000 | 64'(i);
         put(i, 1'b0, 1'b1, op_ld, 12'(i * 8), 28'(100 + i), 64'(i * 3),
             64'hA5A5_0000_0000_0000 | 64'(i));
      end
      put(20, 1'b1, 1'b0, op_ld, 12'd0, 28'd0, 64'd0, 64'd0);
   endtask

   initial begin
      clear_rom();
      do_reset();

      // Reset state
      check_eq("rst_rom_addr", rom_addr_o, 0);
      check_eq("rst_pkt_v", pkt_v_o, 0);
      check_eq("rst_pkt", pkt_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_error", error_o, 0);
      check_eq("rst_err_count", err_count_o, 0);
      check_eq("rst_resp_count", resp_count_o, 0);

      // Store then checked load, correct data
      load_store_trace();
      xor_mask = '0; ready_fix = 1'b1; rand_ready = 1'b0; auto_resp = 1'b1; resp_delay = 2;
      start_req = 1'b1;
      run_to_done("ls_done", 60);
      check_eq("ls_resp_count", resp_count_o, 2);
      check_eq("ls_err_count", err_count_o, 0);
      check_eq("ls_error", error_o, 0);
      check_eq("ls_accepts", acc_cnt, 2);
      check_eq("ls_pkt_v_done", pkt_v_o, 0);

      // Same trace, load returns DEADBEEE
      do_reset();
      load_store_trace();
      xor_mask = 64'h1;
      start_req = 1'b1;
      run_to_done("bad_done", 60);
      check_eq("bad_err_count", err_count_o, 1);
      check_eq("bad_error", error_o, 1);
      check_eq("bad_resp_count", resp_count_o, 2);
      xor_mask = '0;

      // Outstanding limit: 12 loads, responses withheld
      do_reset();
      clear_rom();
      for (int i = 0; i < 12; i++) put(i, 1'b0, 1'b0, op_ld, 12'(i), 28'(i), 64'd0, 64'd0);
      put(12, 1'b1, 1'b0, op_ld, 12'd0, 28'd0, 64'd0, 64'd0);
      auto_resp = 1'b0;
      start_req = 1'b1;
      for (int i = 0; i < 12; i++) step();
      check_eq("full_accepts", acc_cnt, 8);
      check_eq("full_pkt_v", pkt_v_o, 0);
      rel_cnt = 1;
      for (int i = 0; i < 5; i++) step();
      check_eq("rel1_accepts", acc_cnt, 9);
      check_eq("rel1_pkt_v", pkt_v_o, 0);
      // Second of two releases coincides with an accept: count stays put, ends full again.
      rel_cnt = 2;
      for (int i = 0; i < 6; i++) step();
      check_eq("rel2_accepts", acc_cnt, 11);
      check_eq("rel2_pkt_v", pkt_v_o, 0);
      auto_resp = 1'b1;
      run_to_done("full_done", 80);
      check_eq("full_total_accepts", acc_cnt, 12);
      check_eq("full_resp_count", resp_count_o, 12);
      check_eq("full_error", error_o, 0);

      // Random backpressure, 20 entries in order
      do_reset();
      twenty_trace();
      rand_ready = 1'b1; resp_delay = 3;
      start_req = 1'b1;
      run_to_done("bp_done", 400);
      rand_ready = 1'b0;
      check_eq("bp_accepts", acc_cnt, 20);
      check_eq("bp_resp_count", resp_count_o, 20);
      check_eq("bp_error", error_o, 0);
      for (int i = 0; i < 20 && i < acc_pkt.size(); i++) begin
         check_eq($sformatf("bp_pkt%0d", i), acc_pkt[i], {op_ld, 12'(i * 8), 64'(i * 3)});
         check_eq($sformatf("bp_ptag%0d", i), acc_ptag[i], 28'(100 + i));
      end

      // Response in IDLE with empty FIFO, then async reset mid-RUN
      do_reset();
      twenty_trace();
      resp_delay = 2;
      force_v = 1'b1;
      step();
      check_eq("idle_v_error", error_o, 1);
      check_eq("idle_v_resp_count", resp_count_o, 1);
      check_eq("idle_v_done", done_o, 0);
      start_req = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check_eq("mid_run_addr_moved", rom_addr_o != 0, 1);
      #2;
      reset_n_i = 1'b0;
      #1;
      check_eq("arst_rom_addr", rom_addr_o, 0);
      check_eq("arst_pkt_v", pkt_v_o, 0);
      check_eq("arst_pkt", pkt_o, 0);
      check_eq("arst_ptag", ptag_o, 0);
      check_eq("arst_done", done_o, 0);
      check_eq("arst_error", error_o, 0);
      check_eq("arst_err_count", err_count_o, 0);
      check_eq("arst_resp_count", resp_count_o, 0);
      clear_bench();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 3; i++) step();
      check_eq("idle_after_rst_pkt_v", pkt_v_o, 0);
      check_eq("idle_after_rst_accepts", acc_cnt, 0);
      start_req = 1'b1;
      step();
      step();
      check_eq("restart_first_accept", acc_cnt, 1);
      if (acc_pkt.size() > 0) check_eq("restart_first_ptag", acc_ptag[0], 28'd100);

`ifdef BP_BE_DCACHE_TRACE_REPLAY_TIMEOUT_EN
      // Watchdog: one accept, no response
      do_reset();
      clear_rom();
      put(0, 1'b0, 1'b0, op_ld, 12'h020, 28'h5, 64'd0, 64'd0);
      put(1, 1'b1, 1'b0, op_ld, 12'd0, 28'd0, 64'd0, 64'd0);
      auto_resp = 1'b0;
      start_req = 1'b1;
      for (int i = 0; i < 10 && acc_cnt == 0; i++) step();
      check_eq("to_accept", acc_cnt, 1);
      for (int i = 0; i < 15; i++) step();
      check_eq("to_not_yet_done", done_o, 0);
      check_eq("to_not_yet_error", error_o, 0);
      step();
      check_eq("to_done", done_o, 1);
      check_eq("to_error", error_o, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
